// File: rtl/aes128_encrypt_iter_if.sv
// Handshake bundle for the iterative AES-128 encryptor: request side (plaintext/key)
// and response side (ciphertext/final round key).
interface aes128_encrypt_iter_if;
  localparam int unsigned BLK_W = 128;
  localparam int unsigned RND_W = 4;

  logic             in_valid;
  logic             in_ready;
  logic [BLK_W-1:0] plaintext;
  logic [BLK_W-1:0] key;
  logic             out_valid;
  logic             out_ready;
  logic [BLK_W-1:0] ciphertext;
  logic [BLK_W-1:0] key_last;
  logic [RND_W-1:0] round;

  modport master (
    output in_valid, plaintext, key, out_ready,
    input  in_ready, out_valid, ciphertext, key_last, round
  );

  modport slave (
    input  in_valid, plaintext, key, out_ready,
    output in_ready, out_valid, ciphertext, key_last, round
  );
endinterface

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock with on-the-fly forward key expansion.
// key_last exposes the round-10 key so a decrypt core can start its inverse schedule.
module aes128_encrypt_iter (
  input logic                clk,
  input logic                rst,
  aes128_encrypt_iter_if.slave bus
);
  localparam int unsigned BLK_W = 128;
  localparam int unsigned RND_W = 4;
  localparam logic [RND_W-1:0] LAST_ROUND = 4'd10;
  localparam logic [RND_W-1:0] DONE_ROUND = 4'd11;

  // Forward S-box, byte b lives at bits [(255-b)*8 +: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t             fsm;
  logic [BLK_W-1:0] state_q;
  logic [BLK_W-1:0] rkey_q;
  logic [RND_W-1:0] round_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [BLK_W-1:0] nk;
  logic [BLK_W-1:0] round_out;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [RND_W-1:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [BLK_W-1:0] key_exp(input logic [BLK_W-1:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h000000};
    n0 = k[127:96] ^ t;
    n1 = k[95:64]  ^ n0;
    n2 = k[63:32]  ^ n1;
    n3 = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // SubBytes + ShiftRows, optional MixColumns, then AddRoundKey; byte index = row + 4*col.
  function automatic logic [BLK_W-1:0] enc_round(input logic [BLK_W-1:0] s,
                                                 input logic [BLK_W-1:0] k,
                                                 input logic last);
    logic [7:0]       a [16];
    logic [7:0]       b [16];
    logic [7:0]       b0, b1, b2, b3;
    logic [BLK_W-1:0] o;
    for (int i = 0; i < 16; i++) a[4'(i)] = s[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        b[4'(r + 4*c)] = sbox(a[4'(r + 4*((c + r) % 4))]);
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        b0 = b[4'(4*c)];
        b1 = b[4'(4*c + 1)];
        b2 = b[4'(4*c + 2)];
        b3 = b[4'(4*c + 3)];
        b[4'(4*c)]     = xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3;
        b[4'(4*c + 1)] = b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3;
        b[4'(4*c + 2)] = b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3;
        b[4'(4*c + 3)] = xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3);
      end
    end
    o = '0;
    for (int i = 0; i < 16; i++) o = {o[119:0], b[4'(i)]};
    return o ^ k;
  endfunction

  always_comb begin
    nk        = key_exp(rkey_q, rcon(round_q));
    round_out = enc_round(state_q, nk, round_q == LAST_ROUND);
  end

  // Control and datapath registers; handshake flags are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm         <= IDLE;
      state_q     <= '0;
      rkey_q      <= '0;
      round_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            state_q    <= bus.plaintext ^ bus.key;
            rkey_q     <= bus.key;
            round_q    <= 4'd1;
            in_ready_q <= 1'b0;
            fsm        <= RUN;
          end
        end
        RUN: begin
          state_q <= round_out;
          rkey_q  <= nk;
          if (round_q == LAST_ROUND) begin
            round_q     <= DONE_ROUND;
            out_valid_q <= 1'b1;
            fsm         <= DONE;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            round_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            fsm         <= IDLE;
          end
        end
        default: begin
          fsm         <= IDLE;
          round_q     <= '0;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.ciphertext = state_q;
  assign bus.key_last   = rkey_q;
  assign bus.round      = round_q;
endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Directed bench for aes128_encrypt_iter: FIPS-197 vectors, timing, backpressure,
// mid-run reset and a loopback through an independent inverse-cipher model.
module tb_aes128_encrypt_iter;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KL_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] RK1_B = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KL_C  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic clk = 1'b0;
  logic rst;
  aes128_encrypt_iter_if bus ();

  aes128_encrypt_iter dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box derived from GF(2^8) inversion plus the affine map.
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sb[8'(x)] = s;
      isb[s]    = 8'(x);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [7:0]   b [16];
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        b[4'(r + 4*((c + r) % 4))] = isb[byte_of(s, r + 4*c)];
    o = '0;
    for (int i = 0; i < 16; i++) o = {o[119:0], b[4'(i)]};
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = byte_of(s, 4*c); a1 = byte_of(s, 4*c+1);
      a2 = byte_of(s, 4*c+2); a3 = byte_of(s, 4*c+3);
      o = {o[95:0],
           gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09),
           gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d),
           gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b),
           gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e)};
    end
    return o;
  endfunction

  // Inverse cipher driven from the round-10 key via the inverse key schedule.
  function automatic logic [127:0] decrypt(input logic [127:0] ct, input logic [127:0] k10);
    logic [127:0] rk [16];
    logic [7:0]   rc [16];
    logic [31:0]  w0, w1, w2, w3, p0, p1, p2, p3, t;
    logic [127:0] s;
    rc[1] = 8'h01;
    for (int r = 2; r <= 10; r++) rc[4'(r)] = xt(rc[4'(r-1)]);
    rk[10] = k10;
    for (int r = 10; r >= 1; r--) begin
      {w0, w1, w2, w3} = rk[4'(r)];
      p3 = w3 ^ w2; p2 = w2 ^ w1; p1 = w1 ^ w0;
      t  = {sb[p3[23:16]], sb[p3[15:8]], sb[p3[7:0]], sb[p3[31:24]]} ^ {rc[4'(r)], 24'h0};
      p0 = w0 ^ t;
      rk[4'(r-1)] = {p0, p1, p2, p3};
    end
    s = inv_shift_sub(ct ^ rk[10]);
    for (int r = 9; r >= 1; r--) s = inv_shift_sub(inv_mix(s ^ rk[4'(r)]));
    return s ^ rk[0];
  endfunction

  // Accept one block and step to the round-10 edge, checking latency along the way.
  task automatic run_raw(input logic [127:0] k, input logic [127:0] p, input bit chk_e1,
                         input logic [127:0] rk1, output logic [127:0] ct, output logic [127:0] kl);
    int w;
    w = 0;
    while (!bus.in_ready && w < 30) begin tick(); w++; end
    check("in_ready_before_accept", 128'(bus.in_ready), 128'd1);
    bus.plaintext = p; bus.key = k; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("round_after_accept", 128'(bus.round), 128'd1);
    check("rkey_after_accept", bus.key_last, k);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 1 && chk_e1) check("rkey_after_e1", bus.key_last, rk1);
      if (i == 9) check("no_early_valid", 128'(bus.out_valid), 128'd0);
    end
    check("out_valid_at_10", 128'(bus.out_valid), 128'd1);
    check("round_done", 128'(bus.round), 128'd11);
    ct = bus.ciphertext;
    kl = bus.key_last;
  endtask

  task automatic finish_block();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("out_valid_cleared", 128'(bus.out_valid), 128'd0);
    check("in_ready_after_hs", 128'(bus.in_ready), 128'd1);
    check("round_idle", 128'(bus.round), 128'd0);
  endtask

  initial begin
    logic [127:0] ct, kl, k, p;
    logic         seen;
    build_sbox();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.plaintext = '0; bus.key = '0;
    tick(); tick();
    check("rst_in_ready", 128'(bus.in_ready), 128'd0);
    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_ct", bus.ciphertext, 128'd0);
    check("rst_kl", bus.key_last, 128'd0);
    check("rst_round", 128'(bus.round), 128'd0);
    rst = 1'b0;
    tick();
    check("in_ready_after_release", 128'(bus.in_ready), 128'd1);

    run_raw(KEY_B, PT_B, 1'b1, RK1_B, ct, kl);
    check("appB_ct", ct, CT_B);
    check("appB_kl", kl, KL_B);
    finish_block();

    run_raw(KEY_C, PT_C, 1'b0, '0, ct, kl);
    check("appC_ct", ct, CT_C);
    check("appC_kl", kl, KL_C);
    finish_block();

    // Backpressure with a competing request that must be ignored.
    run_raw(KEY_B, PT_B, 1'b0, '0, ct, kl);
    bus.in_valid = 1'b1; bus.plaintext = PT_C; bus.key = KEY_C;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_ct", bus.ciphertext, CT_B);
      check("bp_kl", bus.key_last, KL_B);
      check("bp_valid", 128'(bus.out_valid), 128'd1);
      check("bp_in_ready", 128'(bus.in_ready), 128'd0);
    end
    bus.in_valid = 1'b0;
    finish_block();

    // Back-to-back with in_valid held high.
    bus.plaintext = PT_B; bus.key = KEY_B; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    check("b2b_first_accept", 128'(bus.round), 128'd1);
    bus.plaintext = PT_C; bus.key = KEY_C;
    for (int i = 0; i < 10; i++) tick();
    check("b2b_valid1", 128'(bus.out_valid), 128'd1);
    check("b2b_ct1", bus.ciphertext, CT_B);
    check("b2b_kl1", bus.key_last, KL_B);
    tick();
    check("b2b_e11_round", 128'(bus.round), 128'd0);
    check("b2b_e11_in_ready", 128'(bus.in_ready), 128'd1);
    tick();
    check("b2b_second_accept_e12", 128'(bus.round), 128'd1);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("b2b_valid2", 128'(bus.out_valid), 128'd1);
    check("b2b_ct2", bus.ciphertext, CT_C);
    check("b2b_kl2", bus.key_last, KL_C);
    tick();
    bus.out_ready = 1'b0;
    check("b2b_idle", 128'(bus.in_ready), 128'd1);

    // Reset in the middle of a block.
    bus.plaintext = PT_B; bus.key = KEY_B; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 12 && bus.round != 4'd5; i++) tick();
    check("mid_round5", 128'(bus.round), 128'd5);
    rst = 1'b1;
    #1;
    check("mid_rst_ct", bus.ciphertext, 128'd0);
    check("mid_rst_kl", bus.key_last, 128'd0);
    check("mid_rst_round", 128'(bus.round), 128'd0);
    check("mid_rst_in_ready", 128'(bus.in_ready), 128'd0);
    tick(); tick();
    check("mid_rst_out_valid", 128'(bus.out_valid), 128'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin tick(); seen = seen | bus.out_valid; end
    check("mid_no_stale_valid", 128'(seen), 128'd0);
    run_raw(KEY_C, PT_C, 1'b0, '0, ct, kl);
    check("post_rst_ct", ct, CT_C);
    check("post_rst_kl", kl, KL_C);
    finish_block();

    // Loopback through the inverse cipher.
    for (int n = 0; n < 20; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      run_raw(k, p, 1'b0, '0, ct, kl);
      check("loopback", decrypt(ct, kl), p);
      finish_block();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
